div_nnbit_req_ctrl: RTL
=======================

# div_nnbit_req_ctrl

Request front-end and result collector for the iterative absolute-value divider. It accepts divide requests over a valid/ready handshake and buffers them in a small FIFO. It issues one request at a time to the divider, holding the operands stable for the whole operation, and returns quotient and remainder with a tag over a valid/ready response port. Divide-by-zero and signed overflow are optionally resolved locally, without the divider.

## Interface
Parameters:
- DATA_WIDTH, 8: operand/result width; must match the divider.
- FIFO_DEPTH, 2: request FIFO entries; power of two, ≥2.
- TAG_WIDTH, 4: opaque request tag width.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  FIFO not full.
- i_req_signed  in  1  signed (two's complement) request.
- i_req_num_x  in  DATA_WIDTH  dividend.
- i_req_num_y  in  DATA_WIDTH  divisor.
- i_req_tag  in  TAG_WIDTH  request tag.
- o_div_valid  out  1  start pulse to divider.
- o_div_signed  out  1  held signed flag to divider.
- o_div_num_x  out  DATA_WIDTH  held dividend.
- o_div_num_y  out  DATA_WIDTH  held divisor.
- i_div_res  in  DATA_WIDTH  divider quotient.
- i_div_rem  in  DATA_WIDTH  divider remainder.
- i_div_valid  in  1  divider result pulse.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts.
- o_rsp_res  out  DATA_WIDTH  quotient.
- o_rsp_rem  out  DATA_WIDTH  remainder.
- o_rsp_tag  out  TAG_WIDTH  tag of the request.
- o_rsp_byp  out  1  result produced locally, not by divider.

## Operation
- Reset values: all outputs 0, except o_req_ready, which is 1. FIFO is empty and the FSM is in S_IDLE.
- Push: i_req_valid & o_req_ready writes {signed, x, y, tag} at the write pointer. o_req_ready = !full, registered-state decode only.
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_RESP.
  - S_IDLE, FIFO empty: stay.
  - S_IDLE, FIFO non-empty: pop the head into the operand hold registers (o_div_*, tag). Go to S_RESP if the head is a bypass case, else go to S_ISSUE.
  - S_ISSUE: one cycle. o_div_valid=1. Go to S_WAIT.
  - S_WAIT: wait for i_div_valid. On i_div_valid, capture i_div_res/i_div_rem into the response registers with o_rsp_byp=0. Go to S_RESP.
  - S_RESP: o_rsp_valid=1. Response registers are stable. On i_rsp_ready, go to S_IDLE.
- o_div_signed, o_div_num_x and o_div_num_y stay constant from the pop cycle through the i_div_valid cycle inclusive. The divider samples its sign at result time, so this hold is required.
- o_div_valid is high only in S_ISSUE, so there is exactly one pulse per divider operation.
- i_div_valid outside S_WAIT is ignored.
- Push and pop in the same cycle are permitted when the FIFO is not full. Pointers wrap modulo FIFO_DEPTH, and a separate count disambiguates full from empty.
- Responses return in request order.
- Asynchronous reset mid-operation discards the FIFO contents, any in-flight request and any pending response. The divider shares the reset.

## Timing
- Request accepted into an empty FIFO with the FSM in S_IDLE at edge N:
  - pop at N+1;
  - o_div_valid high during the cycle after N+1 (S_ISSUE);
  - o_rsp_valid high the cycle after i_div_valid.
- Bypass request: o_rsp_valid high two cycles after acceptance.
- One request in flight maximum. The FIFO decouples upstream from divider latency.
- Throughput: one response per (divider latency + 3) cycles when i_rsp_ready is tied high.

## Configuration
- DIV_REQ_CTRL_BYPASS_EN defined: the head is resolved locally, with o_rsp_byp=1 and no o_div_valid, in these cases:
  - y==0: res = all ones, rem = x, for signed and unsigned requests.
  - Signed with x==MIN and y==all ones: res = MIN, rem = 0.
- DIV_REQ_CTRL_BYPASS_EN undefined: every request goes to the divider, o_rsp_byp is tied 0, and no compare logic is built.

## Structure
- Shared package div_pkg:
  - state enum (S_IDLE/S_ISSUE/S_WAIT/S_RESP, one-hot, 4 bits);
  - request struct typedef {signed, num_x, num_y, tag}, parameterised via width constants;
  - bypass result constants.
- Sub-module div_req_fifo: synchronous FIFO with async active-low reset, push/pop/full/empty and a struct payload. All other logic lives in the top module.

## Test plan
- DATA_WIDTH=8, unsigned 100/7 → o_div_valid one pulse; response res=14, rem=2, byp=0, tag echoed.
- Signed 0xF9/0x02 (−7/2) → res=0xFD, rem=0xFF. o_div_signed and the operands are held unchanged until i_div_valid.
- BYPASS_EN, unsigned 0x25/0x00 → res=0xFF, rem=0x25, byp=1, no o_div_valid, o_rsp_valid two cycles after acceptance. Same stimulus without the macro → the request goes to the divider and byp=0.
- BYPASS_EN, signed 0x80/0xFF → res=0x80, rem=0x00, byp=1.
- i_rsp_ready=0 with back-to-back requests, FIFO_DEPTH=2 → exactly 3 requests accepted, then o_req_ready=0. Releasing i_rsp_ready gives 3 in-order responses with tags 1,2,3.
- i_rst_n asserted during S_WAIT → all outputs return to their reset values immediately (o_req_ready=1) and the in-flight response is never emitted. The first request after reset completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the divider request controller: FSM state encoding, request record
// and the locally produced bypass results at the default operand width.
package div_pkg;

  localparam int DIV_DATA_WIDTH = 8;
  localparam int DIV_TAG_WIDTH  = 4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } div_state_e;

  typedef struct packed {
    logic                      sgn;
    logic [DIV_DATA_WIDTH-1:0] num_x;
    logic [DIV_DATA_WIDTH-1:0] num_y;
    logic [DIV_TAG_WIDTH-1:0]  tag;
  } div_req_t;

  // Divide-by-zero yields all ones; MIN / -1 saturates back to MIN with zero remainder.
  localparam logic [DIV_DATA_WIDTH-1:0] DIV_BYP_ZERO_RES = '1;
  localparam logic [DIV_DATA_WIDTH-1:0] DIV_BYP_OVF_RES  = {1'b1, {(DIV_DATA_WIDTH-1){1'b0}}};
  localparam logic [DIV_DATA_WIDTH-1:0] DIV_BYP_OVF_REM  = '0;

endpackage

// File: rtl/div_req_fifo.sv
// Small synchronous request FIFO with a typed payload; a separate occupancy count
// tells full from empty because the pointers wrap modulo DEPTH.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type T_ENTRY = div_req_t
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_push,
  input  T_ENTRY i_data,
  input  logic   i_pop,
  output T_ENTRY o_data,
  output logic   o_full,
  output logic   o_empty
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   L_DEPTH = (PW+1)'(DEPTH);

  T_ENTRY        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == L_DEPTH);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/div_nnbit_req_ctrl.sv
// Request front-end and result collector for the iterative absolute-value divider.
// Define DIV_REQ_CTRL_BYPASS_EN to resolve divide-by-zero and signed overflow locally.
module div_nnbit_req_ctrl
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_WIDTH  = DIV_TAG_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_signed,
  input  logic [DATA_WIDTH-1:0] i_req_num_x,
  input  logic [DATA_WIDTH-1:0] i_req_num_y,
  input  logic [TAG_WIDTH-1:0]  i_req_tag,
  output logic                  o_div_valid,
  output logic                  o_div_signed,
  output logic [DATA_WIDTH-1:0] o_div_num_x,
  output logic [DATA_WIDTH-1:0] o_div_num_y,
  input  logic [DATA_WIDTH-1:0] i_div_res,
  input  logic [DATA_WIDTH-1:0] i_div_rem,
  input  logic                  i_div_valid,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_res,
  output logic [DATA_WIDTH-1:0] o_rsp_rem,
  output logic [TAG_WIDTH-1:0]  o_rsp_tag,
  output logic                  o_rsp_byp
);

  typedef struct packed {
    logic                  sgn;
    logic [DATA_WIDTH-1:0] num_x;
    logic [DATA_WIDTH-1:0] num_y;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  div_state_e            r_state;
  div_state_e            w_state_nxt;
  req_t                  w_push_data;
  req_t                  w_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_pop;
  logic                  w_head_byp;
  logic [DATA_WIDTH-1:0] w_byp_res;
  logic [DATA_WIDTH-1:0] w_byp_rem;

  logic                  r_div_signed;
  logic [DATA_WIDTH-1:0] r_div_x;
  logic [DATA_WIDTH-1:0] r_div_y;
  logic [DATA_WIDTH-1:0] r_rsp_res;
  logic [DATA_WIDTH-1:0] r_rsp_rem;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_rsp_byp;

  assign w_push_data = '{sgn: i_req_signed, num_x: i_req_num_x, num_y: i_req_num_y, tag: i_req_tag};
  assign o_req_ready = !w_fifo_full;

  div_req_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .T_ENTRY (req_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_req_valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifdef DIV_REQ_CTRL_BYPASS_EN
  localparam logic [DATA_WIDTH-1:0] L_ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] L_MIN      = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic w_y_zero;
  logic w_ovf;

  // Divide-by-zero takes priority over overflow; both are decided on the FIFO head.
  assign w_y_zero   = (w_head.num_y == '0);
  assign w_ovf      = w_head.sgn && (w_head.num_x == L_MIN) && (w_head.num_y == L_ALL_ONES);
  assign w_head_byp = w_y_zero || w_ovf;
  assign w_byp_res  = w_y_zero ? L_ALL_ONES : L_MIN;
  assign w_byp_rem  = w_y_zero ? w_head.num_x : '0;
`else
  assign w_head_byp = 1'b0;
  assign w_byp_res  = '0;
  assign w_byp_rem  = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_byp ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (i_div_valid) w_state_nxt = S_RESP;
      S_RESP:  if (i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands load only on pop, so they stay put until the divider answers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_signed <= 1'b0;
      r_div_x      <= '0;
      r_div_y      <= '0;
      r_tag        <= '0;
      r_rsp_res    <= '0;
      r_rsp_rem    <= '0;
      r_rsp_byp    <= 1'b0;
    end else if (w_pop) begin
      r_div_signed <= w_head.sgn;
      r_div_x      <= w_head.num_x;
      r_div_y      <= w_head.num_y;
      r_tag        <= w_head.tag;
      if (w_head_byp) begin
        r_rsp_res <= w_byp_res;
        r_rsp_rem <= w_byp_rem;
        r_rsp_byp <= 1'b1;
      end
    end else if ((r_state == S_WAIT) && i_div_valid) begin
      r_rsp_res <= i_div_res;
      r_rsp_rem <= i_div_rem;
      r_rsp_byp <= 1'b0;
    end
  end

  assign o_div_valid  = (r_state == S_ISSUE);
  assign o_div_signed = r_div_signed;
  assign o_div_num_x  = r_div_x;
  assign o_div_num_y  = r_div_y;
  assign o_rsp_valid  = (r_state == S_RESP);
  assign o_rsp_res    = r_rsp_res;
  assign o_rsp_rem    = r_rsp_rem;
  assign o_rsp_tag    = r_tag;
  assign o_rsp_byp    = r_rsp_byp;

endmodule
